// File: rtl/arbitro_escrita_registradores.sv
// rtl/arbitro_escrita_registradores.sv - round-robin register-file write arbiter with per-register busy scoreboard
// Optional conflict counter enabled by defining ARBITRO_CONTADOR_CONFLITOS_EN.
module arbitro_escrita_registradores #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valido_a,
  input  logic [LARGURA_END-1:0]  endereco_a,
  input  logic [LARGURA_DADO-1:0] dado_a,
  output logic                    pronto_a,
  input  logic                    valido_b,
  input  logic [LARGURA_END-1:0]  endereco_b,
  input  logic [LARGURA_DADO-1:0] dado_b,
  output logic                    pronto_b,
  input  logic                    reserva_valida,
  input  logic [LARGURA_END-1:0]  reserva_endereco,
  input  logic [LARGURA_END-1:0]  endereco_fonte1,
  input  logic [LARGURA_END-1:0]  endereco_fonte2,
  output logic                    ocupado_fonte1,
  output logic                    ocupado_fonte2,
  output logic                    habilita_escrita,
  output logic [LARGURA_END-1:0]  endereco_destino,
  output logic [LARGURA_DADO-1:0] dado_escrita
`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
  ,
  output logic [15:0]             contador_conflitos
`endif
);

  localparam int NREG = 2 ** LARGURA_END;

  // ultimo_b_q = 1 means B was granted most recently, so A wins the next conflict
  logic                    ultimo_b_q;
  logic                    habilita_q;
  logic [LARGURA_END-1:0]  destino_q;
  logic [LARGURA_DADO-1:0] dado_q;
  logic [NREG-1:0]         ocupado_q;
  logic [NREG-1:0]         ocupado_d;

  assign pronto_a = valido_a && (!valido_b || ultimo_b_q);
  assign pronto_b = valido_b && (!valido_a || !ultimo_b_q);

  assign habilita_escrita = habilita_q;
  assign endereco_destino = destino_q;
  assign dado_escrita     = dado_q;
  assign ocupado_fonte1   = ocupado_q[endereco_fonte1];
  assign ocupado_fonte2   = ocupado_q[endereco_fonte2];

  // Clear is applied before set so a same-edge reservation keeps the register busy
  always_comb begin
    ocupado_d = ocupado_q;
    if (habilita_q) begin
      ocupado_d[destino_q] = 1'b0;
    end
    if (reserva_valida && (reserva_endereco != '0)) begin
      ocupado_d[reserva_endereco] = 1'b1;
    end
    ocupado_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ultimo_b_q <= 1'b1;
      habilita_q <= 1'b0;
      destino_q  <= '0;
      dado_q     <= '0;
      ocupado_q  <= '0;
    end else begin
      ocupado_q <= ocupado_d;
      if (pronto_a) begin
        ultimo_b_q <= 1'b0;
        habilita_q <= (endereco_a != '0);
        destino_q  <= endereco_a;
        dado_q     <= dado_a;
      end else if (pronto_b) begin
        ultimo_b_q <= 1'b1;
        habilita_q <= (endereco_b != '0);
        destino_q  <= endereco_b;
        dado_q     <= dado_b;
      end else begin
        habilita_q <= 1'b0;
      end
    end
  end

`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
  logic [15:0] conflitos_q;

  assign contador_conflitos = conflitos_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflitos_q <= '0;
    end else if (valido_a && valido_b && (conflitos_q != 16'hFFFF)) begin
      conflitos_q <= conflitos_q + 16'd1;
    end
  end
`endif

endmodule
